// File: rtl/retire_monitor_pkg.sv
// Shared encodings and default constants for the retirement monitor.
package retire_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_HANG = 2'd3
  } state_t;

  localparam logic [31:0] DEF_HALT_PC     = 32'h0000_00FF;
  localparam int          DEF_DEPTH       = 8;
  localparam int          DEF_STALL_LIMIT = 16;

endpackage

// File: rtl/retire_trace_buf.sv
// Circular trace of retired {pc, instr}; index 0 reads the newest entry.
module retire_trace_buf
  import retire_monitor_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic                       we,
  input  logic [31:0]                pc,
  input  logic [31:0]                instr,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [31:0]                rd_pc,
  output logic [31:0]                rd_instr,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] ridx;

  // Storage is never reset; stale entries are hidden by cnt.
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= {pc, instr};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (we) begin
      wptr <= wptr + AW'(1);
      if (cnt != (AW+1)'(DEPTH)) cnt <= cnt + (AW+1)'(1);
    end
  end

  assign ridx = wptr - rd_idx - AW'(1);

  always_comb begin
    rd_pc    = '0;
    rd_instr = '0;
    if ({1'b0, rd_idx} < cnt) {rd_pc, rd_instr} = mem[ridx];
  end

endmodule

// File: rtl/retire_monitor.sv
// Watches the retirement stream: run/halt/hang tracking, counters and a trace buffer.
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter logic [31:0] HALT_PC     = DEF_HALT_PC,
  parameter int          DEPTH       = DEF_DEPTH,
  parameter int          STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     clear_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_instr_o,
  output logic [$clog2(DEPTH):0]   trace_cnt_o,
  output logic [31:0]              cycle_cnt_o,
  output logic [31:0]              retire_cnt_o,
  output logic [1:0]               state_o,
  output logic                     halted_o,
  output logic                     hang_o
);

  state_t      state_q, state_d;
  logic        accepted;
  logic [7:0]  rep_q, rep_d;
  logic [31:0] last_pc_q, cycle_q, retire_q;
  logic        cycle_inc;

  always_comb begin
    accepted = valid_i && (state_q == ST_IDLE || state_q == ST_RUN) && !clear_i;
    // rep_q == 0 means nothing accepted yet since reset/clear.
    rep_d = (rep_q == 8'd0 || pc_i != last_pc_q) ? 8'd1 : rep_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else if (accepted) begin
      if (pc_i == HALT_PC)                 state_d = ST_HALT;
      else if (rep_d == 8'(STALL_LIMIT))   state_d = ST_HANG;
      else                                 state_d = ST_RUN;
    end
  end

  assign cycle_inc = (state_q == ST_RUN) || (state_q == ST_IDLE && state_d == ST_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rep_q     <= '0;
      last_pc_q <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
    end else if (clear_i) begin
      state_q   <= ST_IDLE;
      rep_q     <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cycle_inc && cycle_q != 32'hFFFF_FFFF) cycle_q <= cycle_q + 32'd1;
      if (accepted) begin
        rep_q     <= rep_d;
        last_pc_q <= pc_i;
        if (retire_q != 32'hFFFF_FFFF) retire_q <= retire_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_o      = state_q;
    halted_o     = (state_q == ST_HALT);
    hang_o       = (state_q == ST_HANG);
    cycle_cnt_o  = cycle_q;
    retire_cnt_o = retire_q;
  end

  retire_trace_buf #(.DEPTH(DEPTH)) u_trace (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear_i),
    .we       (accepted),
    .pc       (pc_i),
    .instr    (instr_i),
    .rd_idx   (rd_idx_i),
    .rd_pc    (rd_pc_o),
    .rd_instr (rd_instr_o),
    .cnt      (trace_cnt_o)
  );

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: directed tables, corner sequences and a random run against a queue model.
module tb_retire_monitor;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam logic [31:0] HPC = 32'h0000_00FF;
  localparam int LIMIT = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [31:0]   pc_i = '0;
  logic [31:0]   instr_i = '0;
  logic [AW-1:0] rd_idx_i = '0;
  logic [31:0]   rd_pc_o, rd_instr_o, cycle_cnt_o, retire_cnt_o;
  logic [AW:0]   trace_cnt_o;
  logic [1:0]    state_o;
  logic          halted_o, hang_o;

  retire_monitor dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .clear_i(clear_i), .rd_idx_i(rd_idx_i), .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o),
    .trace_cnt_o(trace_cnt_o), .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o),
    .state_o(state_o), .halted_o(halted_o), .hang_o(hang_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  int          m_state;
  logic [31:0] m_cyc, m_ret, m_last;
  int          m_rep;
  logic [63:0] m_tr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_ret = 0; m_last = 0; m_rep = 0;
    m_tr.delete();
  endtask

  task automatic model_step(input bit v, input logic [31:0] pc, input logic [31:0] ins, input bit clr);
    bit acc;
    int nrep, nst;
    if (clr) begin
      m_state = 0; m_cyc = 0; m_ret = 0; m_rep = 0;
      m_tr.delete();
      return;
    end
    acc = v && (m_state == 0 || m_state == 1);
    nst = m_state;
    nrep = m_rep;
    if (acc) begin
      nrep = (m_rep == 0 || pc != m_last) ? 1 : m_rep + 1;
      if (pc == HPC) nst = 2;
      else if (nrep == LIMIT) nst = 3;
      else nst = 1;
    end
    if ((m_state == 1 || (m_state == 0 && nst == 1)) && m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (acc) begin
      if (m_ret != 32'hFFFF_FFFF) m_ret++;
      m_tr.push_front({pc, ins});
      if (m_tr.size() > DEPTH) void'(m_tr.pop_back());
      m_last = pc;
      m_rep = nrep;
    end
    m_state = nst;
  endtask

  function automatic logic [63:0] m_read(input int idx);
    if (idx < m_tr.size()) return m_tr[idx];
    return 64'd0;
  endfunction

  task automatic check_all();
    logic [63:0] e;
    e = m_read(int'(rd_idx_i));
    check("state", state_o, m_state);
    check("retire_cnt", retire_cnt_o, m_ret);
    check("cycle_cnt", cycle_cnt_o, m_cyc);
    check("trace_cnt", trace_cnt_o, m_tr.size());
    check("halted", halted_o, m_state == 2);
    check("hang", hang_o, m_state == 3);
    check("rd_pc", rd_pc_o, e[63:32]);
    check("rd_instr", rd_instr_o, e[31:0]);
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input bit clr);
    valid_i  = v;
    pc_i     = pc;
    instr_i  = $urandom();
    clear_i  = clr;
    rd_idx_i = AW'($urandom_range(0, DEPTH - 1));
    @(posedge clk);
    #1;
    model_step(v, pc, instr_i, clr);
    valid_i = 1'b0;
    clear_i = 1'b0;
    check_all();
  endtask

  task automatic read_at(input string name, input int idx, input logic [31:0] exp_pc);
    rd_idx_i = AW'(idx);
    #1;
    check(name, rd_pc_o, exp_pc);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [1:0]  st;
    int unsigned ret;
    int unsigned cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 32'h00, 2'd1, 1, 1};
    tbl[1] = '{1'b1, 32'h04, 2'd1, 2, 2};
    tbl[2] = '{1'b1, 32'h08, 2'd1, 3, 3};
    tbl[3] = '{1'b1, 32'h0C, 2'd1, 4, 4};
    tbl[4] = '{1'b1, 32'hFF, 2'd2, 5, 5};
    tbl[5] = '{1'b1, 32'h10, 2'd2, 5, 5};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    // Run to HALT_PC
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].pc, 1'b0);
      check("tbl_state", state_o, tbl[i].st);
      check("tbl_retire", retire_cnt_o, tbl[i].ret);
      check("tbl_cycle", cycle_cnt_o, tbl[i].cyc);
    end
    read_at("halt_rd0", 0, 32'hFF);
    read_at("halt_rd4", 4, 32'h00);

    // Hang after LIMIT identical retirements
    step(1'b0, 0, 1'b1);
    for (int i = 1; i <= LIMIT; i++) begin
      step(1'b1, 32'h20, 1'b0);
      check("hang_flag", hang_o, i == LIMIT);
    end
    check("hang_retire", retire_cnt_o, 16);
    step(1'b1, 32'h20, 1'b0);
    check("hang_retire_sticky", retire_cnt_o, 16);

    // Trace wrap
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 1'b0);
    check("wrap_cnt", trace_cnt_o, 8);
    read_at("wrap_rd0", 0, 32'h24);
    read_at("wrap_rd7", 7, 32'h08);

    // Clear beats a simultaneous valid
    step(1'b1, 32'h50, 1'b1);
    check("clr_state", state_o, 0);
    check("clr_retire", retire_cnt_o, 0);
    check("clr_cycle", cycle_cnt_o, 0);
    check("clr_trace", trace_cnt_o, 0);
    read_at("clr_rd0", 0, 32'h0);

    // HALT_PC repeated: halt, never hang
    step(1'b1, 32'hFF, 1'b0);
    step(1'b1, 32'hFF, 1'b0);
    check("ff_halted", halted_o, 1'b1);
    check("ff_hang", hang_o, 1'b0);

    // Asynchronous reset mid-run
    step(1'b0, 0, 1'b1);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    check("ar_pre_retire", retire_cnt_o, 3);
    #2;
    rstn = 1'b0;
    rd_idx_i = '0;
    #1;
    model_reset();
    check("ar_state", state_o, 0);
    check("ar_retire", retire_cnt_o, 0);
    check("ar_cycle", cycle_cnt_o, 0);
    check("ar_trace", trace_cnt_o, 0);
    check("ar_rd_pc", rd_pc_o, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, 32'h40, 1'b0);
    check("ar_resume_state", state_o, 1);
    check("ar_resume_retire", retire_cnt_o, 1);

    // Random traffic against the model
    begin
      logic [31:0] rpc;
      rpc = 0;
      for (int n = 0; n < 2000; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) rpc = HPC;
        else if (r >= 85 || rpc == HPC) rpc = 32'($urandom_range(0, 7) * 4);
        step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 29) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
